// File: rtl/band_power_module.sv
// -----------------------------------------------------------------------------
// band_power_module
//
// Takes the complex FFT output one bin per cycle, squares each bin into a power
// value (re^2 + im^2) and sums those powers into five EEG bands (delta, theta,
// alpha, beta, gamma) over one frame. When a frame closes, the five band powers
// appear on the outputs together with a one-cycle valid strobe.
//
// Pipeline: input capture -> S1 (products) -> S2 (sum) -> S3 (accumulate).
// A beat captured at edge T updates the accumulators at edge T+3.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous reset, active low
//   i_fft_real     signed bin real part
//   i_fft_imag     signed bin imaginary part
//   i_fft_valid    bin present this cycle (no back-pressure)
//   i_fft_done     last bin of the frame, qualified by i_fft_valid
//   o_delta..o_gamma  band powers of the last completed frame (unsigned)
//   o_bp_valid     one-cycle strobe when the band outputs update
//   o_frame_err    the reported frame had a length other than EPOCH_LENGTH
// -----------------------------------------------------------------------------
module band_power_module #(
  parameter int EPOCH_LENGTH = 256,
  parameter int EDGE_0       = 1,
  parameter int EDGE_1       = 4,
  parameter int EDGE_2       = 8,
  parameter int EDGE_3       = 13,
  parameter int EDGE_4       = 30,
  parameter int EDGE_5       = 46,
  parameter int ACC_W        = 72
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [31:0]  i_fft_real,
  input  logic signed [31:0]  i_fft_imag,
  input  logic                i_fft_valid,
  input  logic                i_fft_done,
  output logic [ACC_W-1:0]    o_delta,
  output logic [ACC_W-1:0]    o_theta,
  output logic [ACC_W-1:0]    o_alpha,
  output logic [ACC_W-1:0]    o_beta,
  output logic [ACC_W-1:0]    o_gamma,
  output logic                o_bp_valid,
  output logic                o_frame_err
);

  localparam int IDX_W   = $clog2(EPOCH_LENGTH);
  localparam int N_BANDS = 5;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(EPOCH_LENGTH - 1);
  localparam logic [IDX_W-1:0] E0      = IDX_W'(EDGE_0);
  localparam logic [IDX_W-1:0] E1      = IDX_W'(EDGE_1);
  localparam logic [IDX_W-1:0] E2      = IDX_W'(EDGE_2);
  localparam logic [IDX_W-1:0] E3      = IDX_W'(EDGE_3);
  localparam logic [IDX_W-1:0] E4      = IDX_W'(EDGE_4);
  localparam logic [IDX_W-1:0] E5      = IDX_W'(EDGE_5);

  typedef enum logic [2:0] {
    BAND_DELTA = 3'd0,
    BAND_THETA = 3'd1,
    BAND_ALPHA = 3'd2,
    BAND_BETA  = 3'd3,
    BAND_GAMMA = 3'd4,
    BAND_NONE  = 3'd7
  } band_e;

  // Everything a bin needs downstream besides its data.
  typedef struct packed {
    band_e band;
    logic  last;  // this bin closes the frame
    logic  err;   // frame length disagreed with EPOCH_LENGTH
  } tag_t;

  // ---------------------------------------------------------------------------
  // Tag formation from the running bin index
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] bin_idx;
  tag_t             in_tag;
  logic             at_last_idx;

  assign at_last_idx = (bin_idx == LAST_IDX);

  // NOTE: every field gets a default before the if-chain so no latch is inferred.
  always_comb begin
    in_tag      = '{band: BAND_NONE, last: 1'b0, err: 1'b0};
    in_tag.last = i_fft_done | at_last_idx;
    in_tag.err  = i_fft_done ^ at_last_idx;
    if (bin_idx < E0 || bin_idx >= E5) in_tag.band = BAND_NONE;
    else if (bin_idx < E1)             in_tag.band = BAND_DELTA;
    else if (bin_idx < E2)             in_tag.band = BAND_THETA;
    else if (bin_idx < E3)             in_tag.band = BAND_ALPHA;
    else if (bin_idx < E4)             in_tag.band = BAND_BETA;
    else                               in_tag.band = BAND_GAMMA;
  end

  // ---------------------------------------------------------------------------
  // Input capture and bin counter
  // ---------------------------------------------------------------------------
  logic               s0_valid;
  logic signed [31:0] s0_re;
  logic signed [31:0] s0_im;
  tag_t               s0_tag;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin_idx  <= '0;
      s0_valid <= 1'b0;
      s0_re    <= '0;
      s0_im    <= '0;
      s0_tag   <= '{band: BAND_NONE, last: 1'b0, err: 1'b0};
    end else begin
      s0_valid <= i_fft_valid;
      if (i_fft_valid) begin
        s0_re   <= i_fft_real;
        s0_im   <= i_fft_imag;
        s0_tag  <= in_tag;
        bin_idx <= in_tag.last ? '0 : bin_idx + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S1: signed squares (each fits in 64 bits, at most 2^62)
  // ---------------------------------------------------------------------------
  logic signed [63:0] re_ext;
  logic signed [63:0] im_ext;
  logic               s1_valid;
  logic signed [63:0] s1_sq_re;
  logic signed [63:0] s1_sq_im;
  tag_t               s1_tag;

  assign re_ext = 64'(s0_re);
  assign im_ext = 64'(s0_im);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_sq_re <= '0;
      s1_sq_im <= '0;
      s1_tag   <= '{band: BAND_NONE, last: 1'b0, err: 1'b0};
    end else begin
      s1_valid <= s0_valid;
      if (s0_valid) begin
        s1_sq_re <= re_ext * re_ext;
        s1_sq_im <= im_ext * im_ext;
        s1_tag   <= s0_tag;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S2: bin power, treated as unsigned (sum peaks at exactly 2^63)
  // ---------------------------------------------------------------------------
  logic        s2_valid;
  logic [63:0] s2_pow;
  tag_t        s2_tag;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid <= 1'b0;
      s2_pow   <= '0;
      s2_tag   <= '{band: BAND_NONE, last: 1'b0, err: 1'b0};
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_pow <= 64'(s1_sq_re + s1_sq_im);
        s2_tag <= s1_tag;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S3: band accumulation and frame close
  // ---------------------------------------------------------------------------
  logic [ACC_W-1:0] pow_ext;
  logic [ACC_W-1:0] acc      [N_BANDS];
  logic [ACC_W-1:0] acc_sum  [N_BANDS];
  logic [ACC_W-1:0] band_out [N_BANDS];

  assign pow_ext = ACC_W'(s2_pow);

  // Each band's running total including the bin currently in S2; on the last
  // bin this is what gets reported, so the closing bin is never lost.
  always_comb begin
    for (int k = 0; k < N_BANDS; k++) begin
      acc_sum[k] = acc[k];
      if (s2_tag.band == band_e'(3'(k))) acc_sum[k] = acc[k] + pow_ext;
    end
  end

  // NOTE: the accumulator and output arrays are only five entries deep and
  // must read zero straight out of reset, so they are reset explicitly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < N_BANDS; k++) begin
        acc[k]      <= '0;
        band_out[k] <= '0;
      end
      o_bp_valid  <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_bp_valid <= 1'b0;
      if (s2_valid) begin
        for (int k = 0; k < N_BANDS; k++) begin
          if (s2_tag.last) begin
            band_out[k] <= acc_sum[k];
            acc[k]      <= '0;
          end else begin
            acc[k]      <= acc_sum[k];
          end
        end
        if (s2_tag.last) begin
          o_bp_valid  <= 1'b1;
          o_frame_err <= s2_tag.err;
        end
      end
    end
  end

  assign o_delta = band_out[0];
  assign o_theta = band_out[1];
  assign o_alpha = band_out[2];
  assign o_beta  = band_out[3];
  assign o_gamma = band_out[4];

endmodule

// File: tb/tb_band_power_module.sv
// -----------------------------------------------------------------------------
// tb_band_power_module
//
// Directed frames into band_power_module. A frame-level model (per-bin power,
// band lookup by edge table, frame close/err rules) predicts each strobe, its
// cycle and its band values; a compare process checks the DUT every cycle.
// Literal expectations after each scenario pin the model itself.
// -----------------------------------------------------------------------------
module tb_band_power_module;

  localparam int N  = 256;
  localparam int AW = 72;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [31:0] fft_re = '0;
  logic signed [31:0] fft_im = '0;
  logic               fft_valid = 1'b0;
  logic               fft_done  = 1'b0;
  logic [AW-1:0]      o_delta, o_theta, o_alpha, o_beta, o_gamma;
  logic               o_bp_valid, o_frame_err;

  band_power_module dut (
    .clk        (clk),
    .rst        (rst),
    .i_fft_real (fft_re),
    .i_fft_imag (fft_im),
    .i_fft_valid(fft_valid),
    .i_fft_done (fft_done),
    .o_delta    (o_delta),
    .o_theta    (o_theta),
    .o_alpha    (o_alpha),
    .o_beta     (o_beta),
    .o_gamma    (o_gamma),
    .o_bp_valid (o_bp_valid),
    .o_frame_err(o_frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int tests = 0;
  int fails = 0;
  bit started = 0;

  // ---------------------------------------------------------------------------
  // Frame-level model
  // ---------------------------------------------------------------------------
  typedef struct {
    int            due;
    logic [AW-1:0] band [5];
    logic          err;
  } exp_t;

  exp_t          q[$];
  exp_t          cur;
  logic [AW-1:0] macc [5];
  int            midx = 0;
  int            edges [6] = '{1, 4, 8, 13, 30, 46};

  logic signed [31:0] fre [N];
  logic signed [31:0] fim [N];

  task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int k = 0; k < 5; k++) begin
      cur.band[k] = '0;
      macc[k]     = '0;
    end
    cur.err = 1'b0;
    midx    = 0;
  endtask

  // Called at the negedge where the beat is driven; the beat is sampled at the
  // next rising edge and its frame strobe is visible after three more edges.
  task automatic model_beat(input logic signed [31:0] re, input logic signed [31:0] im,
                            input logic d);
    logic signed [AW-1:0] sr;
    logic signed [AW-1:0] si;
    logic [AW-1:0]        pw;
    bit                   at_end;
    exp_t                 e;
    sr = re;
    si = im;
    pw = sr * sr + si * si;
    for (int k = 0; k < 5; k++)
      if (midx >= edges[k] && midx < edges[k+1]) macc[k] += pw;
    at_end = (midx == N - 1);
    if (d || at_end) begin
      e.due = cyc + 4;
      for (int k = 0; k < 5; k++) begin
        e.band[k] = macc[k];
        macc[k]   = '0;
      end
      e.err = (d != at_end);
      q.push_back(e);
      midx = 0;
    end else begin
      midx++;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Compare process: strobe timing every cycle, outputs hold between strobes
  // ---------------------------------------------------------------------------
  initial begin
    bit exp_v;
    wait (started);
    forever begin
      @(negedge clk);
      #2;
      exp_v = (q.size() > 0) && (q[0].due == cyc);
      check("bp_valid", AW'(o_bp_valid), AW'(exp_v));
      if (exp_v) cur = q.pop_front();
      check("delta", o_delta, cur.band[0]);
      check("theta", o_theta, cur.band[1]);
      check("alpha", o_alpha, cur.band[2]);
      check("beta",  o_beta,  cur.band[3]);
      check("gamma", o_gamma, cur.band[4]);
      check("frame_err", AW'(o_frame_err), AW'(cur.err));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      fft_valid = 1'b0;
      fft_done  = 1'b0;
      fft_re    = '0;
      fft_im    = '0;
    end
  endtask

  task automatic beat(input logic signed [31:0] re, input logic signed [31:0] im, input logic d);
    @(negedge clk);
    fft_valid = 1'b1;
    fft_done  = d;
    fft_re    = re;
    fft_im    = im;
    model_beat(re, im, d);
  endtask

  task automatic clear_frame();
    for (int i = 0; i < N; i++) begin
      fre[i] = '0;
      fim[i] = '0;
    end
  endtask

  task automatic send_frame(input int n, input bit with_done, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) idle($urandom_range(0, 2));
      beat(fre[i], fim[i], with_done && (i == n - 1));
    end
  endtask

  task automatic check_out(input string tag, input logic [AW-1:0] d, input logic [AW-1:0] t,
                           input logic [AW-1:0] a, input logic [AW-1:0] b,
                           input logic [AW-1:0] g, input logic e);
    check({tag, "_delta"}, o_delta, d);
    check({tag, "_theta"}, o_theta, t);
    check({tag, "_alpha"}, o_alpha, a);
    check({tag, "_beta"},  o_beta,  b);
    check({tag, "_gamma"}, o_gamma, g);
    check({tag, "_err"},   AW'(o_frame_err), AW'(e));
  endtask

  // ---------------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------------
  initial begin
    logic [AW-1:0] p63;
    p63 = 72'h1 << 63;

    model_reset();
    #3 rst = 1'b0;
    idle(3);
    check_out("reset", '0, '0, '0, '0, '0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    started = 1;

    // Single-bin tone in alpha.
    clear_frame();
    fre[10] = 32'sd3;
    fim[10] = 32'sd4;
    send_frame(N, 1, 0);
    idle(6);
    check_out("tone", '0, '0, 72'd25, '0, '0, 1'b0);

    // Band edges: unit power in every bin.
    clear_frame();
    for (int i = 0; i < N; i++) fre[i] = 32'sd1;
    send_frame(N, 1, 0);
    idle(6);
    check_out("edges", 72'd3, 72'd4, 72'd5, 72'd17, 72'd16, 1'b0);

    // Extreme values: every in-band bin at the most negative input.
    clear_frame();
    for (int i = 1; i <= 45; i++) begin
      fre[i] = 32'sh8000_0000;
      fim[i] = 32'sh8000_0000;
    end
    send_frame(N, 1, 0);
    idle(6);
    check_out("extreme", 3 * p63, 4 * p63, 5 * p63, 17 * p63,
              72'h8_0000_0000_0000_0000, 1'b0);

    // Back-to-back frames, no gap between done and the next bin 0.
    clear_frame();
    fre[5] = 32'sd2;
    send_frame(N, 1, 0);
    fre[5] = 32'sd1;
    send_frame(N, 1, 0);
    idle(6);
    check_out("b2b", '0, 72'd1, '0, '0, '0, 1'b0);

    // Short frame: done at index 99, then a clean tone frame from bin 0.
    clear_frame();
    fre[10] = 32'sd3;
    fim[10] = 32'sd4;
    fre[50] = 32'sd7;
    send_frame(100, 1, 0);
    idle(6);
    check_out("short", '0, '0, 72'd25, '0, '0, 1'b1);
    fre[50] = '0;
    send_frame(N, 1, 0);
    idle(6);
    check_out("after_short", '0, '0, 72'd25, '0, '0, 1'b0);

    // Long frame: 256 beats without done.
    clear_frame();
    fre[2] = 32'sd2;
    send_frame(N, 0, 0);
    idle(6);
    check_out("nodone", 72'd4, '0, '0, '0, '0, 1'b1);

    // Random gaps give the gapless result.
    clear_frame();
    fre[10] = 32'sd3;
    fim[10] = 32'sd4;
    send_frame(N, 1, 1);
    idle(6);
    check_out("gaps", '0, '0, 72'd25, '0, '0, 1'b0);

    // Reset at bin 120 discards the partial frame.
    clear_frame();
    for (int i = 0; i < N; i++) fre[i] = 32'sd1;
    send_frame(120, 0, 0);
    @(negedge clk);
    rst       = 1'b0;
    fft_valid = 1'b0;
    model_reset();
    #1;
    check_out("midreset", '0, '0, '0, '0, '0, 1'b0);
    idle(2);
    @(negedge clk);
    rst = 1'b1;
    clear_frame();
    fre[10] = 32'sd3;
    fim[10] = 32'sd4;
    send_frame(N, 1, 0);
    idle(6);
    check_out("post_reset", '0, '0, 72'd25, '0, '0, 1'b0);

    idle(4);
    check("strobes_drained", AW'(q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/band_power_module.md
# band_power_module

Downstream stage of the FFT block in the feature-extraction chain. Consumes the complex FFT output stream one bin per cycle, forms the power of each bin (re² + im²) and accumulates it into five EEG frequency bands (delta, theta, alpha, beta, gamma) over one epoch. At the end of each epoch it presents the five band powers to the classifier-side logic with a one-cycle valid strobe.

## Interface
Parameters:
- EPOCH_LENGTH, 256: FFT points per frame; bins indexed 0..EPOCH_LENGTH-1.
- EDGE_0, 1: first delta bin.
- EDGE_1, 4: first theta bin (delta = [EDGE_0, EDGE_1)).
- EDGE_2, 8: first alpha bin.
- EDGE_3, 13: first beta bin.
- EDGE_4, 30: first gamma bin.
- EDGE_5, 46: gamma upper bound, exclusive. Requires EDGE_0 < … < EDGE_5 ≤ EPOCH_LENGTH/2.
- ACC_W, 72: accumulator and output width.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous, active-low reset.
- i_fft_real, input, 32 signed: bin real part.
- i_fft_imag, input, 32 signed: bin imaginary part.
- i_fft_valid, input, 1: bin present this cycle. There is no back-pressure; every valid beat must be accepted.
- i_fft_done, input, 1: last bin of frame; qualified by i_fft_valid.
- o_delta / o_theta / o_alpha / o_beta / o_gamma, output, ACC_W unsigned: band powers of the last completed frame.
- o_bp_valid, output, 1: one-cycle strobe when the band outputs update.
- o_frame_err, output, 1: the frame just reported had a length other than EPOCH_LENGTH; updated with o_bp_valid.

## Operation
- Bin counter bin_idx (clog2(EPOCH_LENGTH) bits) increments on every accepted beat. It resets to 0 after a beat with i_fft_done=1 or after the beat at index EPOCH_LENGTH-1.
- Frame close happens on the first of these two events:
  - accepted beat with i_fft_done=1, or
  - accepted beat at bin_idx = EPOCH_LENGTH-1.
- frame_err for the frame = done and index disagree, i.e. done seen at index ≠ EPOCH_LENGTH-1, or index EPOCH_LENGTH-1 reached without done.
- Power per bin:
  - re·re and im·im are signed 32×32 products with 64-bit results, each non-negative.
  - Their sum is 64-bit unsigned and cannot overflow (maximum 2^63).
  - The sum is zero-extended to ACC_W. ACC_W=72 cannot overflow for EPOCH_LENGTH ≤ 256. There is no saturation logic.
- Band selection: a bin with EDGE_k ≤ bin_idx < EDGE_k+1 adds to band k. Bins outside [EDGE_0, EDGE_5), including DC and the upper half of the spectrum, are discarded.
- The bin tag (band id or none, plus last and err flags) travels alongside the data through the pipeline.
- Three-stage pipeline:
  - S1 registers the two products and the tag.
  - S2 registers the sum and the tag.
  - S3 updates the accumulators.
- On a last-tagged beat in S3:
  - each output register loads acc_k plus this bin's power if the bin is in band k;
  - all five accumulators clear to 0 in the same cycle;
  - o_bp_valid pulses and o_frame_err loads the tag's err flag.
- Back-to-back frames are supported: bin 0 of the next frame may arrive the cycle after done. It enters S3 after the clear and accumulates normally.
- Outputs hold their value between strobes.

## Timing
- Reset (rst=0, asynchronous) clears everything to 0:
  - all outputs;
  - accumulators, pipeline valids, tags and bin_idx.
- Operation resumes on the first rising edge after rst deasserts.
- A reset mid-frame discards the partial frame; the next beat is treated as bin 0.
- Latency: a beat sampled at edge T reaches S1 at T+1 and S2 at T+2, and updates the accumulators at T+3. For the last beat, o_bp_valid is high for exactly the cycle following edge T+3.
- Throughput: one bin per cycle sustained, with no gaps required.
- Gaps (i_fft_valid=0) anywhere are tolerated. The pipeline carries a valid bit per stage.
- i_fft_done while i_fft_valid=0 is ignored.

## Test plan
- Single-bin tone: a 256-beat frame, all zero except bin 10 with re=3, im=4, done at index 255 -> o_alpha=25, others 0, o_frame_err=0; o_bp_valid one cycle, 3 edges after the done beat.
- Band edges: every bin re=1, im=0 -> o_delta=3, o_theta=4, o_alpha=5, o_beta=17, o_gamma=16.
- Extreme values: all bins 1..45 with re=im=-2^31 -> o_gamma = 16·2^63 = 2^67 exactly, with no wrap; signed products are verified.
- Back-to-back frames: frame A with bin 5 re=2 (power 4), then frame B with no gap and bin 5 re=1 -> strobes 256 cycles apart with o_theta=4 then 1; the clear is verified to lose no bin.
- Length errors:
  - done at index 99 -> strobe with o_frame_err=1, and the next frame starts at bin 0;
  - 256 beats with no done -> strobe at beat 255 with o_frame_err=1.
- Reset and gaps: a frame with random valid gaps matches the gapless result. Asserting rst at bin 120 clears all outputs to 0 immediately, and a following clean frame reports only its own power.
